// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, mstatus field positions,
// FSM state encodings, cause codes and the mstatus rewrite helpers.
package trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int CAUSE_ECALL_M = 11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_T_EPC   = 3'd1,
    ST_T_CAUSE = 3'd2,
    ST_T_STAT  = 3'd3,
    ST_T_VEC   = 3'd4,
    ST_R_STAT  = 3'd5,
    ST_R_EPC   = 3'd6
  } trap_state_t;

  // Only the low 13 bits of mstatus are touched; callers splice the upper bits back.
  function automatic logic [12:0] mstatus_enter(input logic [12:0] s);
    logic [12:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [12:0] mstatus_return(input logic [12:0] s);
    logic [12:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_sequencer.sv
// Sequences ecall trap entry and mret return over a single CSR port,
// stalling decode until the final state redirects the PC.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CAUSE_ECALL = CAUSE_ECALL_M
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [11:0]     csr_raddr_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            csr_wen_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  trap_state_t     state_reg, state_next;
  logic [XLEN-1:0] saved_pc_reg, saved_pc_next;
  logic            accept;

  assign accept = valid_i && (ecall_i || mret_i);
  assign busy_o = (state_reg != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      saved_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      saved_pc_reg <= saved_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    saved_pc_next = saved_pc_reg;
    csr_raddr_o   = 12'h000;
    csr_wen_o     = 1'b0;
    csr_waddr_o   = 12'h000;
    csr_wdata_o   = '0;
    stall_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          stall_o       = 1'b1;
          saved_pc_next = pc_i;
          // ecall takes priority when decode flags both
          state_next    = ecall_i ? ST_T_EPC : ST_R_STAT;
        end
      end
      ST_T_EPC: begin
        stall_o     = 1'b1;
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = saved_pc_reg;
        state_next  = ST_T_CAUSE;
      end
      ST_T_CAUSE: begin
        stall_o     = 1'b1;
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = XLEN'(CAUSE_ECALL);
        state_next  = ST_T_STAT;
      end
      ST_T_STAT: begin
        stall_o     = 1'b1;
        csr_raddr_o = CSR_MSTATUS;
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = {csr_rdata_i[XLEN-1:13], mstatus_enter(csr_rdata_i[12:0])};
        state_next  = ST_T_VEC;
      end
      ST_T_VEC: begin
        csr_raddr_o   = CSR_MTVEC;
        redirect_o    = 1'b1;
        // mtvec low bits hold the vector mode; only direct mode is supported
        redirect_pc_o = {csr_rdata_i[XLEN-1:2], 2'b00};
        state_next    = ST_IDLE;
      end
      ST_R_STAT: begin
        stall_o     = 1'b1;
        csr_raddr_o = CSR_MSTATUS;
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = {csr_rdata_i[XLEN-1:13], mstatus_return(csr_rdata_i[12:0])};
        state_next  = ST_R_EPC;
      end
      ST_R_EPC: begin
        csr_raddr_o   = CSR_MEPC;
        redirect_o    = 1'b1;
        redirect_pc_o = csr_rdata_i;
        state_next    = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
